// File: rtl/pwm_axil_pkg.sv
// Shared definitions for the PWM AXI4-Lite slave: register offsets, response code, CTRL field layout.
package pwm_axil_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_PERIOD  = 4'h4;
  localparam logic [3:0] ADDR_DUTY    = 4'h8;
  localparam logic [3:0] ADDR_SCRATCH = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_PSC_LSB = 16;
  localparam int CTRL_PSC_MSB = 31;

  localparam int NUM_REGS = 4;

endpackage

// File: rtl/pwm_core.sv
// Prescaled PWM engine whose period/duty shadows reload only at period wrap.
// Latency: pwm_out lags the period counter by one register; no backpressure, free-running when enabled.
module pwm_core
  import pwm_axil_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] prescale,
  input  logic [31:0] period,
  input  logic [31:0] duty,
  output logic        pwm_out,
  output logic        period_tick
);

  logic [15:0] psc_cnt;
  logic [31:0] cnt;
  logic [31:0] period_sh;
  logic [31:0] duty_sh;
  logic        tick;
  logic        wrap;

  assign tick = (psc_cnt == prescale);
  assign wrap = (cnt == period_sh - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt     <= '0;
      cnt         <= '0;
      period_sh   <= '0;
      duty_sh     <= '0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else if (!enable) begin
      psc_cnt     <= '0;
      cnt         <= '0;
      period_sh   <= period;
      duty_sh     <= duty;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= 1'b0;
      // A zero period parks the output low regardless of duty.
      pwm_out     <= (period_sh != 32'd0) && (cnt < duty_sh);
      psc_cnt     <= tick ? 16'd0 : psc_cnt + 16'd1;
      if (tick) begin
        if (period_sh == 32'd0) begin
          cnt       <= '0;
          period_sh <= period;
          duty_sh   <= duty;
        end else if (wrap) begin
          cnt         <= '0;
          period_sh   <= period;
          duty_sh     <= duty;
          period_tick <= 1'b1;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_axil_slave.sv
// AXI4-Lite register file (CTRL/PERIOD/DUTY/SCRATCH) fronting the PWM core.
// Latency: write visible and BVALID one cycle after handshake, RDATA one cycle after ARREADY; one transaction of each kind outstanding, held until B/R ready.
module pwm_axil_slave
  import pwm_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out,
  output logic                            period_tick
);

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                          wr_rdy;
  logic                          rd_rdy;
  logic                          wr_en;
  logic                          rd_en;
  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg;
  logic                          unused_ok;

  assign wr_en = wr_rdy & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en = rd_rdy & S_AXI_ARVALID;

  assign S_AXI_AWREADY = wr_rdy;
  assign S_AXI_WREADY  = wr_rdy;
  assign S_AXI_ARREADY = rd_rdy;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;

  // AW and W are only accepted together; the READY pulse is a single cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_rdy       <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      rd_rdy       <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      wr_rdy <= S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~wr_rdy;
      rd_rdy <= S_AXI_ARVALID & ~S_AXI_RVALID & ~rd_rdy;

      if (wr_en) begin
        S_AXI_BVALID <= 1'b1;
        for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
          if (S_AXI_WSTRB[b]) regs[S_AXI_AWADDR[3:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      // Sampled before any same-edge write lands, so a colliding read sees the old value.
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= regs[S_AXI_ARADDR[3:2]];
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  assign ctrl_reg = regs[ADDR_CTRL[3:2]];

  pwm_core u_pwm_core (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .enable      (ctrl_reg[CTRL_EN_BIT]),
    .prescale    (ctrl_reg[CTRL_PSC_MSB:CTRL_PSC_LSB]),
    .period      (regs[ADDR_PERIOD[3:2]]),
    .duty        (regs[ADDR_DUTY[3:2]]),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                       ctrl_reg[CTRL_PSC_LSB-1:CTRL_EN_BIT+1]};

endmodule

// File: tb/tb_pwm_axil_slave.sv
// Randomized self-checking bench for pwm_axil_slave with a register scoreboard and a period/duty waveform model.
module tb_pwm_axil_slave;
  import pwm_axil_pkg::*;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETN = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic        pwm_out, period_tick;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] reg_model [4];

  always #5 tb_ACLK = ~tb_ACLK;

  pwm_axil_slave dut (
    .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESETN(tb_ARESETN),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge tb_ACLK);
      #1;
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int t = 0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && t < 20) begin cyc(); t++; end
    check_val("wr_handshake", 32'(awready && wready), 32'd1);
    reg_model[addr[3:2]] = merge(reg_model[addr[3:2]], data, strb);
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    check_val("bvalid_rise", 32'(bvalid), 32'd1);
    check_val("bresp", 32'(bresp), 32'(RESP_OKAY));
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    check_val("bvalid_fall", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int t = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && t < 20) begin cyc(); t++; end
    check_val("rd_handshake", 32'(arready), 32'd1);
    cyc();
    arvalid = 1'b0;
    check_val("rvalid_rise", 32'(rvalid), 32'd1);
    check_val("rresp", 32'(rresp), 32'(RESP_OKAY));
    data = rdata;
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    check_val("rvalid_fall", 32'(rvalid), 32'd0);
  endtask

  task automatic read_check(input logic [3:0] addr, input string tag);
    logic [31:0] d;
    axi_read(addr, d);
    check_val(tag, d, reg_model[addr[3:2]]);
  endtask

  task automatic wait_tick(input int bound);
    int t = 0;
    while (!period_tick && t < bound) begin cyc(); t++; end
    check_val("tick_seen", 32'(period_tick), 32'd1);
  endtask

  // Called one cycle after a sampled period_tick: one period of (prescale+1)-cycle slots,
  // high for the first 'duty' slots, next tick landing on the final cycle.
  task automatic measure_period(input int period, input int duty, input int psc);
    int len = period * (psc + 1);
    for (int j = 0; j < len; j++) begin
      cyc();
      check_val("pwm_wave", 32'(pwm_out), 32'((j / (psc + 1)) < duty));
      check_val("tick_pos", 32'(period_tick), 32'(j == len - 1));
    end
  endtask

  task automatic setup_pwm(input int period, input int duty, input int psc);
    axi_write(ADDR_CTRL, 32'h0, 4'hF);
    axi_write(ADDR_PERIOD, 32'(period), 4'hF);
    axi_write(ADDR_DUTY, 32'(duty), 4'hF);
    axi_write(ADDR_CTRL, {16'(psc), 16'h0001}, 4'hF);
  endtask

  initial begin
    logic [31:0] pre, d0;
    int pulses, p, dt, ps;
    for (int i = 0; i < 4; i++) reg_model[i] = '0;

    cyc(3);
    check_val("rst_awready", 32'(awready), 32'd0);
    check_val("rst_wready", 32'(wready), 32'd0);
    check_val("rst_bvalid", 32'(bvalid), 32'd0);
    check_val("rst_arready", 32'(arready), 32'd0);
    check_val("rst_rvalid", 32'(rvalid), 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_pwm", 32'(pwm_out), 32'd0);
    check_val("rst_tick", 32'(period_tick), 32'd0);
    tb_ARESETN = 1'b1;
    cyc(2);

    // Directed register write/readback
    axi_write(ADDR_CTRL, 32'h0101FFFF, 4'hF);    read_check(ADDR_CTRL, "rb_ctrl");
    axi_write(ADDR_PERIOD, 32'habcd0001, 4'hF);  read_check(ADDR_PERIOD, "rb_period");
    axi_write(ADDR_DUTY, 32'hdead0011, 4'hF);    read_check(ADDR_DUTY, "rb_duty");
    axi_write(ADDR_SCRATCH, 32'hbeef0011, 4'hF); read_check(ADDR_SCRATCH, "rb_scratch");
    axi_write(ADDR_SCRATCH, 32'h12345678, 4'b0010);
    axi_read(ADDR_SCRATCH, d0);
    check_val("rb_strobe", d0, 32'hbeef5611);

    // Colliding read and write to one register returns the old contents
    pre = reg_model[3];
    fork
      axi_write(ADDR_SCRATCH, 32'hA5A5C3C3, 4'hF);
      begin
        logic [31:0] dr;
        axi_read(ADDR_SCRATCH, dr);
        check_val("rw_collide", dr, pre);
      end
    join
    read_check(ADDR_SCRATCH, "rb_after_collide");

    // AW held without W: no acceptance until both valid, BVALID held under backpressure
    awaddr = ADDR_DUTY; wdata = 32'h0000_0077; wstrb = 4'hF; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_val("aw_only_rdy", 32'(awready | wready), 32'd0);
    end
    wvalid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (awready && wready) pulses++;
    end
    check_val("aw_w_pulses", 32'(pulses), 32'd1);
    reg_model[2] = 32'h0000_0077;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("bvalid_hold", 32'(bvalid), 32'd1);
      cyc();
    end
    bready = 1'b1; cyc(); bready = 1'b0;
    check_val("bvalid_release", 32'(bvalid), 32'd0);
    read_check(ADDR_DUTY, "rb_duty_late_w");

    // PWM: period 4, duty 1, no prescale
    setup_pwm(4, 1, 0);
    wait_tick(100);
    repeat (3) measure_period(4, 1, 0);

    // Duty change mid-period only takes effect at the next wrap
    setup_pwm(4, 3, 3);
    wait_tick(200);
    fork
      measure_period(4, 3, 3);
      begin
        cyc(3);
        axi_write(ADDR_DUTY, 32'd2, 4'hF);
      end
    join
    measure_period(4, 2, 3);

    // Zero period: output parked low, no ticks
    setup_pwm(0, 5, 0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_val("p0_pwm", 32'(pwm_out), 32'd0);
      check_val("p0_tick", 32'(period_tick), 32'd0);
    end

    // Disable forces output low
    setup_pwm(3, 5, 0);
    wait_tick(100);
    axi_write(ADDR_CTRL, 32'h0, 4'hF);
    cyc();
    check_val("dis_pwm", 32'(pwm_out), 32'd0);
    check_val("dis_tick", 32'(period_tick), 32'd0);

    // Randomized waveform configurations
    for (int k = 0; k < 4; k++) begin
      p  = $urandom_range(1, 6);
      dt = $urandom_range(0, 8);
      ps = $urandom_range(0, 2);
      setup_pwm(p, dt, ps);
      wait_tick(400);
      repeat (2) measure_period(p, dt, ps);
    end

    // Randomized register traffic against the scoreboard
    for (int k = 0; k < 12; k++) begin
      logic [3:0] a;
      a = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      axi_write(a, $urandom, 4'($urandom_range(0, 15)));
      read_check({2'($urandom_range(0, 3)), 2'b00}, "rb_random");
    end

    // Reset while a read response is pending
    setup_pwm(4, 2, 0);
    wait_tick(100);
    araddr = ADDR_PERIOD; arvalid = 1'b1;
    for (int t = 0; t < 20 && !arready; t++) cyc();
    cyc();
    arvalid = 1'b0;
    check_val("pend_rvalid", 32'(rvalid), 32'd1);
    d0 = rdata;
    cyc(2);
    check_val("pend_rdata_stable", rdata, d0);
    check_val("pend_rdata", rdata, reg_model[1]);
    #3 tb_ARESETN = 1'b0;
    #1;
    check_val("arst_rvalid", 32'(rvalid), 32'd0);
    check_val("arst_pwm", 32'(pwm_out), 32'd0);
    check_val("arst_tick", 32'(period_tick), 32'd0);
    cyc(2);
    tb_ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) reg_model[i] = '0;
    cyc();
    read_check(ADDR_CTRL, "post_rst_ctrl");
    read_check(ADDR_PERIOD, "post_rst_period");
    read_check(ADDR_DUTY, "post_rst_duty");
    read_check(ADDR_SCRATCH, "post_rst_scratch");
    check_val("post_rst_pwm", 32'(pwm_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
